// File: rtl/idu_ctrl_stage_if.sv
// idu_ctrl_stage_if
//   Bundles the upstream fetch handshake (instruction + PC), the downstream
//   handshake and the decoded control word presented to EXU.
//   master : the environment side (drives in_valid/in_inst/in_pc/out_ready)
//   slave  : the decode stage (drives in_ready, out_valid and the payload)
interface idu_ctrl_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;

    logic [2:0]      ExtOp;
    logic            RegWr;
    logic            MemtoReg;
    logic            MemWr;
    logic [2:0]      MemOp;
    logic            ALUAsrc;
    logic [1:0]      ALUBsrc;
    logic [3:0]      ALUctr;
    logic [2:0]      Branch;
    logic            word;
    logic            mdu;
    logic [2:0]      mdu_op;
    logic            illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc,
        input  ExtOp, RegWr, MemtoReg, MemWr, MemOp, ALUAsrc, ALUBsrc,
        input  ALUctr, Branch, word, mdu, mdu_op, illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc,
        output ExtOp, RegWr, MemtoReg, MemWr, MemOp, ALUAsrc, ALUBsrc,
        output ALUctr, Branch, word, mdu, mdu_op, illegal
    );
endinterface

// File: rtl/idu_ctrl_stage.sv
// idu_ctrl_stage
//   Registered control-decode stage. The incoming instruction is decoded
//   combinationally; the control word plus inst/pc is captured into a one-
//   or two-entry output buffer on acceptance and presented to EXU one cycle
//   later.
//   Parameters: XLEN (32/64), EN_M (decode M extension), DEPTH (1 or 2).
//   Ports: clk, rst_n (async, active low), flush (sync, drops all entries),
//          bus (idu_ctrl_stage_if.slave: in/out handshakes + control word).
module idu_ctrl_stage #(
    parameter int XLEN  = 32,
    parameter bit EN_M  = 1'b0,
    parameter int DEPTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    idu_ctrl_stage_if.slave       bus
);

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM32 = 5'b00110;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_OP32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_U = 3'b001;
    localparam logic [2:0] EXT_S = 3'b010;
    localparam logic [2:0] EXT_B = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    localparam logic [1:0] B_RS2 = 2'b00;
    localparam logic [1:0] B_IMM = 2'b01;
    localparam logic [1:0] B_4   = 2'b10;
    localparam logic [1:0] B_CSR = 2'b11;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SLT   = 4'b0010;
    localparam logic [3:0] ALU_SLTU  = 4'b1010;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0011;

    typedef struct packed {
        logic [2:0] ext_op;
        logic       reg_wr;
        logic       mem_to_reg;
        logic       mem_wr;
        logic [2:0] mem_op;
        logic       alu_a_src;
        logic [1:0] alu_b_src;
        logic [3:0] alu_ctr;
        logic [2:0] branch;
        logic       word;
        logic       mdu;
        logic [2:0] mdu_op;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        ctrl_t           ctrl;
    } entry_t;

    // ALU op from func3; alt selects sub (func3 000) or sra (func3 101).
    // sltu is the only func3 whose encoding needs bit 3 set unconditionally.
    function automatic logic [3:0] alu_ctr_f(input logic [2:0] f3, input logic alt);
        logic [3:0] r;
        case (f3)
            3'b000:  r = {alt, 3'b000};
            3'b011:  r = ALU_SLTU;
            3'b101:  r = {alt, 3'b101};
            default: r = {1'b0, f3};
        endcase
        return r;
    endfunction

    logic [4:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    ctrl_t      dec;
    logic       ill;
    logic       is_word;

    assign op = bus.in_inst[6:2];
    assign f3 = bus.in_inst[14:12];
    assign f7 = bus.in_inst[31:25];

    always_comb begin
        dec     = '0;
        ill     = (bus.in_inst[1:0] != 2'b11);
        is_word = 1'b0;
        case (op)
            OPC_LUI: begin
                dec.ext_op    = EXT_U;
                dec.reg_wr    = 1'b1;
                dec.alu_b_src = B_IMM;
                dec.alu_ctr   = ALU_PASSB;
            end
            OPC_AUIPC: begin
                dec.ext_op    = EXT_U;
                dec.reg_wr    = 1'b1;
                dec.alu_a_src = 1'b1;
                dec.alu_b_src = B_IMM;
                dec.alu_ctr   = ALU_ADD;
            end
            OPC_JAL: begin
                dec.ext_op    = EXT_J;
                dec.reg_wr    = 1'b1;
                dec.alu_a_src = 1'b1;
                dec.alu_b_src = B_4;
                dec.branch    = 3'b001;
            end
            OPC_JALR: begin
                dec.ext_op    = EXT_I;
                dec.reg_wr    = 1'b1;
                dec.alu_a_src = 1'b1;
                dec.alu_b_src = B_4;
                dec.branch    = 3'b010;
            end
            OPC_BRANCH: begin
                dec.ext_op    = EXT_B;
                dec.alu_b_src = B_RS2;
                // func3[1] marks the unsigned compares; {1,f3[2],f3[0]} maps
                // beq/bne/blt(u)/bge(u) onto 100/101/110/111.
                dec.alu_ctr   = f3[1] ? ALU_SLTU : ALU_SLT;
                dec.branch    = {1'b1, f3[2], f3[0]};
                if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
            end
            OPC_LOAD: begin
                dec.ext_op     = EXT_I;
                dec.reg_wr     = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.mem_op     = f3;
                dec.alu_b_src  = B_IMM;
                if (f3 == 3'b111) ill = 1'b1;
                if (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110)) ill = 1'b1;
            end
            OPC_STORE: begin
                dec.ext_op    = EXT_S;
                dec.mem_wr    = 1'b1;
                dec.mem_op    = f3;
                dec.alu_b_src = B_IMM;
                if (f3[2]) ill = 1'b1;
                if (XLEN == 32 && f3 == 3'b011) ill = 1'b1;
            end
            OPC_OP_IMM, OPC_OP_IMM32: begin
                dec.ext_op    = EXT_I;
                dec.reg_wr    = 1'b1;
                dec.alu_b_src = B_IMM;
                // Immediate forms never subtract; bit 30 only picks srai.
                dec.alu_ctr   = alu_ctr_f(f3, f7[5] && (f3 == 3'b101));
                is_word       = (op == OPC_OP_IMM32);
            end
            OPC_OP, OPC_OP32: begin
                dec.reg_wr    = 1'b1;
                dec.alu_b_src = B_RS2;
                is_word       = (op == OPC_OP32);
                if (f7 == 7'b0000000) begin
                    dec.alu_ctr = alu_ctr_f(f3, 1'b0);
                end else if (f7 == 7'b0100000) begin
                    dec.alu_ctr = alu_ctr_f(f3, 1'b1);
                    if (f3 != 3'b000 && f3 != 3'b101) ill = 1'b1;
                end else if (EN_M && f7 == 7'b0000001) begin
                    dec.mdu     = 1'b1;
                    dec.mdu_op  = f3;
                    dec.alu_ctr = ALU_ADD;
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                case (f3)
                    3'b000: ;
                    3'b001: begin
                        dec.reg_wr    = 1'b1;
                        dec.alu_b_src = B_CSR;
                        dec.alu_ctr   = ALU_PASSB;
                    end
                    3'b010: begin
                        dec.reg_wr    = 1'b1;
                        dec.alu_b_src = B_CSR;
                        dec.alu_ctr   = ALU_OR;
                    end
                    default: ill = 1'b1;
                endcase
            end
            OPC_MISC_MEM: ;
            default: ill = 1'b1;
        endcase

        if (is_word) begin
            if (XLEN == 32) ill = 1'b1;
            else            dec.word = 1'b1;
        end

        // Illegal instructions carry no side effects downstream.
        if (ill) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // Output buffer: ent0 is the head presented to EXU, ent1 the skid slot.
    entry_t     ent0_q, ent0_d, ent1_q, ent1_d, new_ent;
    logic [1:0] cnt_q, cnt_d;
    logic       rdy_q, rdy_d;
    logic       in_ready, out_valid, push, pop;

    assign new_ent   = {bus.in_inst, bus.in_pc, dec};
    assign out_valid = (cnt_q != 2'd0);
    assign in_ready  = (DEPTH == 1) ? ((cnt_q == 2'd0) || bus.out_ready) : rdy_q;
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    always_comb begin
        cnt_d  = cnt_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (push) begin
                        ent0_d = new_ent;
                        cnt_d  = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        ent0_d = new_ent;
                    end else if (push) begin
                        ent1_d = new_ent;
                        cnt_d  = 2'd2;
                    end else if (pop) begin
                        cnt_d = 2'd0;
                    end
                end
                default: begin
                    // Full: in_ready is low, so only a pop can happen.
                    if (pop) begin
                        ent0_d = ent1_q;
                        cnt_d  = 2'd1;
                    end
                end
            endcase
        end
        rdy_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            rdy_q  <= 1'b1;
            ent0_q <= '0;
            ent1_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            rdy_q  <= rdy_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_inst  = ent0_q.inst;
    assign bus.out_pc    = ent0_q.pc;
    assign bus.ExtOp     = ent0_q.ctrl.ext_op;
    assign bus.RegWr     = ent0_q.ctrl.reg_wr;
    assign bus.MemtoReg  = ent0_q.ctrl.mem_to_reg;
    assign bus.MemWr     = ent0_q.ctrl.mem_wr;
    assign bus.MemOp     = ent0_q.ctrl.mem_op;
    assign bus.ALUAsrc   = ent0_q.ctrl.alu_a_src;
    assign bus.ALUBsrc   = ent0_q.ctrl.alu_b_src;
    assign bus.ALUctr    = ent0_q.ctrl.alu_ctr;
    assign bus.Branch    = ent0_q.ctrl.branch;
    assign bus.word      = ent0_q.ctrl.word;
    assign bus.mdu       = ent0_q.ctrl.mdu;
    assign bus.mdu_op    = ent0_q.ctrl.mdu_op;
    assign bus.illegal   = ent0_q.ctrl.illegal;

endmodule
